// File: rtl/parity_serial_rx_pkg.sv
// Shared types and constants for the parity serial link (receive side today,
// transmit-side generator later).
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int DATA_W_DEFAULT = 4;
  // start + data + parity + stop
  localparam int FRAME_LEN      = DATA_W_DEFAULT + 3;

endpackage

// File: rtl/parity_serial_rx_if.sv
// Serial line in, checked word plus status out. The master drives the line and
// consumes results; the slave is the receiver.
interface parity_serial_rx_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              sin;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              perr;
  logic              ferr;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output sin,
    input  dout, dout_valid, perr, ferr, busy, err_cnt
  );

  modport slave (
    input  sin,
    output dout, dout_valid, perr, ferr, busy, err_cnt
  );
endinterface

// File: rtl/parity_serial_rx_calc.sv
// Reduction-XOR parity of a data word; shared with the transmit-side generator.
module parity_calc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);
  assign par = ^data;
endmodule

// File: rtl/parity_serial_rx.sv
// Frame receiver: start, DATA_W bits LSB first, even parity, stop. Reports the
// word with parity/framing flags and keeps a saturating error count.
module parity_serial_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  parity_serial_rx_if.slave  bus
);

  localparam int CW = $clog2(DATA_W + 1);

  rx_state_t         state_q, state_n;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              par_bit;
  logic              data_par;
  logic              perr_n;
  logic              ferr_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data (shift_q),
    .par  (data_par)
  );

  assign perr_n   = data_par ^ par_bit;
  assign ferr_n   = ~bus.sin;
  assign bus.busy = (state_q != IDLE);

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:   if (!bus.sin) state_n = DATA;
      DATA:   if (bit_cnt == CW'(DATA_W - 1)) state_n = PARITY;
      PARITY: state_n = STOP;
      STOP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt        <= '0;
      shift_q        <= '0;
      par_bit        <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.perr       <= 1'b0;
      bus.ferr       <= 1'b0;
      bus.err_cnt    <= '0;
    end else begin
      state_q        <= state_n;
      bus.dout_valid <= 1'b0;
      bus.perr       <= 1'b0;
      bus.ferr       <= 1'b0;
      case (state_q)
        IDLE: bit_cnt <= '0;
        DATA: begin
          // Shift right with new bits at the MSB so the first bit ends at bit 0
          shift_q <= {bus.sin, shift_q[DATA_W-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
        end
        PARITY: par_bit <= bus.sin;
        STOP: begin
          bus.dout       <= shift_q;
          bus.dout_valid <= 1'b1;
          bus.perr       <= perr_n;
          bus.ferr       <= ferr_n;
          if (perr_n || ferr_n) bus.err_cnt <= sat_inc(bus.err_cnt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx: hand-built frames with known results.
module tb_parity_serial_rx;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  parity_serial_rx_if #(.DATA_W(4), .CNT_W(8)) bus ();

  parity_serial_rx #(.DATA_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  int vcount;
  int t1, t2;

  initial begin
    reset   = 1'b1;
    bus.sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_perr", 32'(bus.perr), 0);
    check("rst_ferr", 32'(bus.ferr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_errcnt", 32'(bus.err_cnt), 0);

    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      if (bus.dout_valid) vcount++;
    end
    check("idle_no_valid", 32'(vcount), 0);

    // Good frame 0101, parity 0
    send_frame(4'b0101, 1'b0, 1'b1);
    check("good_valid", 32'(bus.dout_valid), 1);
    check("good_dout", 32'(bus.dout), 32'h5);
    check("good_perr", 32'(bus.perr), 0);
    check("good_ferr", 32'(bus.ferr), 0);
    check("good_errcnt", 32'(bus.err_cnt), 0);
    send_bit(1'b1);
    check("good_valid_drop", 32'(bus.dout_valid), 0);
    check("good_dout_hold", 32'(bus.dout), 32'h5);

    // Parity error: 0001 with parity 0
    send_frame(4'b0001, 1'b0, 1'b1);
    check("perr_valid", 32'(bus.dout_valid), 1);
    check("perr_dout", 32'(bus.dout), 32'h1);
    check("perr_perr", 32'(bus.perr), 1);
    check("perr_ferr", 32'(bus.ferr), 0);
    check("perr_errcnt", 32'(bus.err_cnt), 1);
    send_bit(1'b1);
    check("perr_drop", 32'(bus.perr), 0);

    // Framing error only: 0111 parity 1 stop 0
    send_frame(4'b0111, 1'b1, 1'b0);
    check("ferr_valid", 32'(bus.dout_valid), 1);
    check("ferr_dout", 32'(bus.dout), 32'h7);
    check("ferr_perr", 32'(bus.perr), 0);
    check("ferr_ferr", 32'(bus.ferr), 1);
    check("ferr_errcnt", 32'(bus.err_cnt), 2);
    send_bit(1'b1);
    check("ferr_drop", 32'(bus.ferr), 0);

    // Double error: 1111 parity 1 stop 0, counted once
    send_frame(4'b1111, 1'b1, 1'b0);
    check("dbl_dout", 32'(bus.dout), 32'hF);
    check("dbl_perr", 32'(bus.perr), 1);
    check("dbl_ferr", 32'(bus.ferr), 1);
    check("dbl_errcnt", 32'(bus.err_cnt), 3);
    send_bit(1'b1);
    send_bit(1'b1);

    // Back-to-back: 1011 parity 1, then 0110 parity 0, no idle between
    send_frame(4'b1011, 1'b1, 1'b1);
    t1 = cyc;
    check("b2b1_valid", 32'(bus.dout_valid), 1);
    check("b2b1_dout", 32'(bus.dout), 32'hB);
    check("b2b1_perr", 32'(bus.perr), 0);
    send_frame(4'b0110, 1'b0, 1'b1);
    t2 = cyc;
    check("b2b2_valid", 32'(bus.dout_valid), 1);
    check("b2b2_dout", 32'(bus.dout), 32'h6);
    check("b2b2_perr", 32'(bus.perr), 0);
    check("b2b_spacing", 32'(t2 - t1), 7);
    check("b2b_errcnt", 32'(bus.err_cnt), 3);
    send_bit(1'b1);

    // Reset after two data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy_before", 32'(bus.busy), 1);
    reset   = 1'b1;
    bus.sin = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_valid", 32'(bus.dout_valid), 0);
    check("mid_errcnt", 32'(bus.err_cnt), 0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (bus.dout_valid) vcount++;
    end
    check("mid_no_valid", 32'(vcount), 0);
    send_frame(4'b1010, 1'b0, 1'b1);
    check("post_valid", 32'(bus.dout_valid), 1);
    check("post_dout", 32'(bus.dout), 32'hA);
    check("post_perr", 32'(bus.perr), 0);
    check("post_ferr", 32'(bus.ferr), 0);

    // Saturation: 260 parity-error frames back to back
    for (int i = 0; i < 260; i++) begin
      send_frame(4'b0001, 1'b0, 1'b1);
      if (i == 254) check("sat_reach", 32'(bus.err_cnt), 255);
    end
    check("sat_hold", 32'(bus.err_cnt), 255);
    check("sat_perr", 32'(bus.perr), 1);
    send_bit(1'b1);
    check("sat_final", 32'(bus.err_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Serial frame receiver that sits directly downstream of a 4-bit parity generator on the transmit side.
- Samples one bit per clock: start bit, DATA_W data bits (LSB first), even-parity bit, stop bit.
- Reassembles the nibble, recomputes the XOR parity, and flags parity and framing errors.
- Feeds checked nibbles to the consumer and keeps a saturating error count for debug.

Parameters:
- DATA_W, 4, number of data bits per frame (>= 2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial line, one bit per cycle, idles high.
- dout  output  DATA_W  last received data word.
- dout_valid  output  1  one-cycle pulse, frame complete.
- perr  output  1  qualified by dout_valid: parity mismatch.
- ferr  output  1  qualified by dout_valid: stop bit was 0.
- busy  output  1  high while a frame is in progress (state != IDLE).
- err_cnt  output  CNT_W  frames with perr or ferr, saturating.

Behaviour:
- Single clock domain, clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE; bit counter 0; shift register 0.
  - dout = 0, dout_valid = 0, perr = 0, ferr = 0, busy = 0, err_cnt = 0.
- Frame length is 2 + DATA_W + 1 cycles (7 for DATA_W = 4).
- State machine:
  - IDLE: sin == 0 → DATA, bit counter cleared. Otherwise stay.
  - DATA: shift sin in at the MSB, shifting right, so the first bit received lands at bit 0. Counter increments. After DATA_W bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: sample sin and return to IDLE unconditionally.
- On the STOP edge the following register updates:
  - dout ← shift register.
  - dout_valid ← 1.
  - perr ← (XOR of data bits) ^ parity bit. Even parity: XOR of data plus parity bit must be 0.
  - ferr ← ~sin.
- dout_valid, perr, ferr:
  - Visible the cycle after the stop bit is sampled.
  - Held high for exactly one cycle. perr and ferr return to 0 with dout_valid.
- dout holds its value until the next completed frame.
- err_cnt:
  - Increments by 1 per frame with (perr | ferr); a frame with both errors counts once.
  - Saturates at 2^CNT_W − 1 and never wraps.
- A frame with a framing error still produces dout_valid with ferr = 1. dout carries the received bits.
- Back-to-back frames: a start bit may arrive in the cycle immediately after STOP. IDLE detects it with no lost cycle.
- The start bit is not re-verified; any 0 sampled in IDLE begins a frame.
- Reset mid-frame: return to IDLE next edge. No dout_valid is produced for the partial frame, and err_cnt clears.
- No back-pressure. The consumer must accept dout while dout_valid is high.

Decomposition:
- Shared package parity_pkg holds:
  - typedef enum logic [1:0] rx_state_t {IDLE, DATA, PARITY, STOP}.
  - Constant DATA_W_DEFAULT = 4.
  - Constant FRAME_LEN = DATA_W_DEFAULT + 3.
- One combinational sub-module, parity_calc (DATA_W-wide reduction XOR). It is reused by a future transmit-side generator.
- The FSM, shift register, counters and output registers stay in parity_serial_rx.

Test Plan:
- Reset: hold reset 2 cycles with sin = 1 → all outputs 0, busy = 0; 20 idle cycles → dout_valid never asserts.
- Good frame: sin = 0, 1,0,1,0, 0, 1 (data 4'b0101, parity 0, stop 1) → dout = 4'b0101, dout_valid for exactly 1 cycle, perr = 0, ferr = 0, err_cnt = 0.
- Parity error: data 4'b0001 sent as 1,0,0,0 with parity 0, stop 1 → dout = 4'b0001, perr = 1, ferr = 0, err_cnt = 1.
- Framing and double error: data 4'b0111 with parity 1, stop 0 → ferr = 1, perr = 0, err_cnt + 1. Then data 4'b1111 with parity 1, stop 0 → perr = 1, ferr = 1, err_cnt + 1 only.
- Back-to-back: frames 4'b1011 (parity 1) and 4'b0110 (parity 0) with no idle between → two dout_valid pulses exactly 7 cycles apart, correct dout each, err_cnt unchanged.
- Reset mid-frame and saturation:
  - Assert reset after 2 data bits → no dout_valid, busy = 0 next cycle; a following good frame decodes correctly.
  - 260 consecutive parity-error frames → err_cnt = 255 and holds.
